// File: rtl/hazard_unit_p.sv
// hazard_unit_p: decode-side forwarding, interlock, branch flush and MDU occupancy control
module hazard_unit_p #(
    parameter int NUM_SRC = 2,
    parameter int ADDR_W  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_SRC*ADDR_W-1:0] rs_d,
    input  logic [NUM_SRC-1:0]        rs_used_d,
    input  logic [ADDR_W-1:0]         e_dst,
    input  logic [ADDR_W-1:0]         m_dst,
    input  logic [ADDR_W-1:0]         w_dst,
    input  logic                      e_wr,
    input  logic                      m_wr,
    input  logic                      w_wr,
    input  logic                      e_is_load,
    input  logic                      m_is_load,
    input  logic                      e_branch,
    input  logic                      e_mdu_start,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      flush_m,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      mdu_done,
    output logic [CNT_W-1:0]          stall_cnt
);
    localparam int CW = $clog2(MDU_LAT + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [NUM_SRC-1:0] me, mm, mw;
    logic dhaz, mdu_stall, done;
    // any E producer interlocks, so the E load flag carries no extra information
    logic unused_e_is_load;
    assign unused_e_is_load = e_is_load;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [ADDR_W-1:0] rs;
        assign rs = rs_d[i*ADDR_W +: ADDR_W];
        assign me[i] = rs_used_d[i] && e_wr && e_dst == rs && rs != '0;
        assign mm[i] = rs_used_d[i] && m_wr && m_dst == rs && rs != '0;
        assign mw[i] = rs_used_d[i] && w_wr && w_dst == rs && rs != '0;
        assign fwd_sel[2*i +: 2] = (mm[i] && !m_is_load) ? 2'b01 : mw[i] ? 2'b10 : 2'b00;
    end
    assign dhaz = |me || (|mm && m_is_load);
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        mdu_stall = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: if (e_mdu_start) begin
                mdu_stall = 1'b1;
                if (MDU_LAT == 2) state_nx = DONE;
                else begin
                    cnt_nx = CW'(MDU_LAT - 2);
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                mdu_stall = 1'b1;
                if (cnt == CW'(1)) state_nx = DONE;
                else cnt_nx = cnt - 1'b1;
            end
            DONE: begin
                done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // controls are forced low during reset; only the operand selects stay live
    assign stall_f  = resetn && (mdu_stall || (!e_branch && dhaz));
    assign stall_d  = stall_f;
    assign stall_e  = resetn && mdu_stall;
    assign flush_m  = stall_e;
    assign flush_d  = resetn && !mdu_stall && e_branch;
    assign flush_e  = resetn && !mdu_stall && (e_branch || dhaz);
    assign mdu_done = resetn && done;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (stall_f && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit_p.sv
// tb_hazard_unit_p: directed and randomized checks of hazard_unit_p against a cycle-level reference model
module tb_hazard_unit_p;
    logic clk = 1'b0;
    logic resetn;
    logic [9:0] rs_d;
    logic [1:0] rs_used_d;
    logic [4:0] e_dst, m_dst, w_dst;
    logic e_wr, m_wr, w_wr, e_is_load, m_is_load, e_branch, e_mdu_start;
    logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_done;
    logic [3:0] fwd_sel;
    logic [31:0] stall_cnt;
    logic stall_f2, stall_d2, stall_e2, flush_d2, flush_e2, flush_m2, mdu_done2;
    logic [3:0] fwd_sel2;
    logic [2:0] stall_cnt2;
    logic [10:0] obs1, obs2;
    int checks = 0, passes = 0;
    int opos1 = 0, opos2 = 0, cnt1 = 0, cnt2 = 0;

    always #5 clk = ~clk;

    hazard_unit_p dut (
        .clk(clk), .resetn(resetn), .rs_d(rs_d), .rs_used_d(rs_used_d),
        .e_dst(e_dst), .m_dst(m_dst), .w_dst(w_dst), .e_wr(e_wr), .m_wr(m_wr), .w_wr(w_wr),
        .e_is_load(e_is_load), .m_is_load(m_is_load), .e_branch(e_branch), .e_mdu_start(e_mdu_start),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .flush_d(flush_d),
        .flush_e(flush_e), .flush_m(flush_m), .fwd_sel(fwd_sel), .mdu_done(mdu_done),
        .stall_cnt(stall_cnt)
    );

    hazard_unit_p #(.MDU_LAT(2), .CNT_W(3)) dut2 (
        .clk(clk), .resetn(resetn), .rs_d(rs_d), .rs_used_d(rs_used_d),
        .e_dst(e_dst), .m_dst(m_dst), .w_dst(w_dst), .e_wr(e_wr), .m_wr(m_wr), .w_wr(w_wr),
        .e_is_load(e_is_load), .m_is_load(m_is_load), .e_branch(e_branch), .e_mdu_start(e_mdu_start),
        .stall_f(stall_f2), .stall_d(stall_d2), .stall_e(stall_e2), .flush_d(flush_d2),
        .flush_e(flush_e2), .flush_m(flush_m2), .fwd_sel(fwd_sel2), .mdu_done(mdu_done2),
        .stall_cnt(stall_cnt2)
    );

    assign obs1 = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_done, fwd_sel};
    assign obs2 = {stall_f2, stall_d2, stall_e2, flush_d2, flush_e2, flush_m2, mdu_done2, fwd_sel2};

    // position of the current cycle inside an MDU op: 0 idle, 1..lat
    function automatic int cur(input int op);
        return (op == 0 && e_mdu_start) ? 1 : op;
    endfunction

    // expected {sf,sd,se,fd,fe,fm,done,fwd[3:0]}
    function automatic logic [10:0] model(input int pos, input int lat);
        logic [3:0] fwd;
        logic [6:0] ctl;
        bit haz, em, mm, wm;
        int rs;
        haz = 0;
        fwd = '0;
        for (int i = 0; i < 2; i++) begin
            rs = int'(rs_d[i*5 +: 5]);
            em = rs_used_d[i] && e_wr && int'(e_dst) == rs && rs != 0;
            mm = rs_used_d[i] && m_wr && int'(m_dst) == rs && rs != 0;
            wm = rs_used_d[i] && w_wr && int'(w_dst) == rs && rs != 0;
            fwd[2*i +: 2] = (mm && !m_is_load) ? 2'd1 : wm ? 2'd2 : 2'd0;
            haz = haz || em || (mm && m_is_load);
        end
        ctl = (pos >= 1 && pos < lat) ? 7'b1110010 : e_branch ? 7'b0001100 : haz ? 7'b1100100 : 7'b0;
        ctl[0] = (pos == lat);
        return resetn ? {ctl, fwd} : {7'b0, fwd};
    endfunction

    task automatic tick();
        logic [10:0] a, b;
        int c1, c2;
        c1 = cur(opos1);
        c2 = cur(opos2);
        a = model(c1, 4);
        b = model(c2, 2);
        @(posedge clk);
        if (resetn) begin
            opos1 = (c1 == 0 || c1 == 4) ? 0 : c1 + 1;
            opos2 = (c2 == 0 || c2 == 2) ? 0 : c2 + 1;
            if (a[10]) cnt1++;
            if (b[10] && cnt2 < 7) cnt2++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rs_d = '0; rs_used_d = '0; e_dst = '0; m_dst = '0; w_dst = '0;
        e_wr = 0; m_wr = 0; w_wr = 0; e_is_load = 0; m_is_load = 0; e_branch = 0; e_mdu_start = 0;
    endtask

    task automatic test_reset();
        resetn = 0;
        idle_inputs();
        e_wr = 1; e_dst = 5'd3; rs_d = {5'd3, 5'd3}; rs_used_d = 2'b11; e_mdu_start = 1; e_branch = 1;
        #2;
        checks++; if (obs1[10:4] !== 7'b0) $display("FAIL reset_ctl got %b exp 0", obs1[10:4]); else passes++;
        checks++; if (stall_cnt !== 32'd0) $display("FAIL reset_cnt got %0d exp 0", stall_cnt); else passes++;
        @(posedge clk); #1;
        checks++; if (obs2[10:4] !== 7'b0) $display("FAIL reset_ctl2 got %b exp 0", obs2[10:4]); else passes++;
        checks++; if (stall_cnt2 !== 3'd0) $display("FAIL reset_cnt2 got %0d exp 0", stall_cnt2); else passes++;
        idle_inputs();
        resetn = 1;
        opos1 = 0; opos2 = 0; cnt1 = 0; cnt2 = 0;
    endtask

    task automatic test_forward();
        logic [10:0] e;
        logic [3:0] want [3];
        want = '{4'b0101, 4'b1010, 4'b0101};
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            rs_d = {5'd5, 5'd5}; rs_used_d = 2'b11; m_dst = 5'd5; w_dst = 5'd5;
            m_wr = (k != 1); w_wr = (k != 0);
            @(negedge clk);
            e = model(cur(opos1), 4);
            checks++; if (fwd_sel !== want[k]) $display("FAIL fwd_%0d got %b exp %b", k, fwd_sel, want[k]); else passes++;
            checks++; if (obs1 !== e) $display("FAIL fwd_model_%0d got %b exp %b", k, obs1, e); else passes++;
            tick();
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        rs_d = {5'd0, 5'd7}; rs_used_d = 2'b01; e_wr = 1; e_is_load = 1; e_dst = 5'd7;
        @(negedge clk);
        checks++; if ({stall_f, stall_d, flush_e} !== 3'b111) $display("FAIL lu_c1 got %b exp 111", {stall_f, stall_d, flush_e}); else passes++;
        tick();
        e_wr = 0; e_is_load = 0; m_wr = 1; m_is_load = 1; m_dst = 5'd7;
        @(negedge clk);
        checks++; if ({stall_f, stall_d, flush_e} !== 3'b111) $display("FAIL lu_c2 got %b exp 111", {stall_f, stall_d, flush_e}); else passes++;
        tick();
        m_wr = 0; m_is_load = 0; w_wr = 1; w_dst = 5'd7;
        @(negedge clk);
        checks++; if ({stall_f, flush_e, fwd_sel[1:0]} !== 4'b0010) $display("FAIL lu_c3 got %b exp 0010", {stall_f, flush_e, fwd_sel[1:0]}); else passes++;
        checks++; if (stall_cnt !== 32'd2) $display("FAIL lu_cnt got %0d exp 2", stall_cnt); else passes++;
        tick();
    endtask

    task automatic test_x0_unused();
        logic [1:0] used [3];
        logic [9:0] rs [3];
        logic [4:0] dst [3];
        logic want [3];
        used = '{2'b01, 2'b01, 2'b11};
        rs = '{10'd0, {5'd3, 5'd0}, {5'd3, 5'd0}};
        dst = '{5'd0, 5'd3, 5'd3};
        want = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            e_wr = 1; e_dst = dst[k]; rs_d = rs[k]; rs_used_d = used[k];
            @(negedge clk);
            checks++; if (stall_f !== want[k]) $display("FAIL x0_%0d got %b exp %b", k, stall_f, want[k]); else passes++;
            tick();
        end
    endtask

    task automatic test_mdu();
        logic [10:0] e;
        idle_inputs();
        e_mdu_start = 1; e_branch = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 4 < 3) begin
                checks++; if ({stall_f, stall_e, flush_m, flush_d, mdu_done} !== 5'b11100) $display("FAIL mdu_stall_%0d got %b exp 11100", k, {stall_f, stall_e, flush_m, flush_d, mdu_done}); else passes++;
            end else begin
                checks++; if ({stall_e, flush_m, mdu_done} !== 3'b001) $display("FAIL mdu_done_%0d got %b exp 001", k, {stall_e, flush_m, mdu_done}); else passes++;
            end
            e = model(cur(opos2), 2);
            checks++; if (obs2 !== e) $display("FAIL mdu2_%0d got %b exp %b", k, obs2, e); else passes++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_branch_vs_hazard();
        idle_inputs();
        e_wr = 1; e_dst = 5'd4; rs_d = {5'd0, 5'd4}; rs_used_d = 2'b01; e_branch = 1;
        @(negedge clk);
        checks++; if ({flush_d, flush_e, stall_f, stall_d} !== 4'b1100) $display("FAIL br_haz got %b exp 1100", {flush_d, flush_e, stall_f, stall_d}); else passes++;
        tick();
        e_branch = 0;
        @(negedge clk);
        checks++; if ({flush_d, flush_e, stall_f, stall_d} !== 4'b0111) $display("FAIL haz_only got %b exp 0111", {flush_d, flush_e, stall_f, stall_d}); else passes++;
        tick();
    endtask

    task automatic test_async_reset();
        logic [10:0] e;
        idle_inputs();
        e_mdu_start = 1;
        tick();
        tick();
        #2;
        checks++; if (stall_e !== 1'b1) $display("FAIL busy_pre got %b exp 1", stall_e); else passes++;
        resetn = 0;
        #1;
        checks++; if (obs1[10:4] !== 7'b0) $display("FAIL arst_ctl got %b exp 0", obs1[10:4]); else passes++;
        checks++; if (stall_cnt !== 32'd0) $display("FAIL arst_cnt got %0d exp 0", stall_cnt); else passes++;
        checks++; if (stall_cnt2 !== 3'd0) $display("FAIL arst_cnt2 got %0d exp 0", stall_cnt2); else passes++;
        opos1 = 0; opos2 = 0; cnt1 = 0; cnt2 = 0;
        @(posedge clk); #1;
        e_mdu_start = 0;
        resetn = 1;
        @(negedge clk);
        checks++; if (mdu_done !== 1'b0) $display("FAIL arst_nodone got %b exp 0", mdu_done); else passes++;
        e = model(cur(opos1), 4);
        checks++; if (obs1 !== e) $display("FAIL arst_model got %b exp %b", obs1, e); else passes++;
        tick();
    endtask

    task automatic test_random();
        logic [10:0] e1, e2;
        bit req;
        req = 0;
        for (int k = 0; k < 400; k++) begin
            rs_d = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            rs_used_d = 2'($urandom);
            e_dst = 5'($urandom_range(0, 3)); m_dst = 5'($urandom_range(0, 3)); w_dst = 5'($urandom_range(0, 3));
            e_wr = 1'($urandom); m_wr = 1'($urandom); w_wr = 1'($urandom);
            e_is_load = 1'($urandom); m_is_load = 1'($urandom);
            e_branch = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) req = !req;
            e_mdu_start = req;
            @(negedge clk);
            e1 = model(cur(opos1), 4);
            e2 = model(cur(opos2), 2);
            checks++; if (obs1 !== e1) $display("FAIL rnd_%0d got %b exp %b", k, obs1, e1); else passes++;
            checks++; if (obs2 !== e2) $display("FAIL rnd2_%0d got %b exp %b", k, obs2, e2); else passes++;
            checks++; if (stall_cnt !== 32'(cnt1)) $display("FAIL rnd_cnt_%0d got %0d exp %0d", k, stall_cnt, cnt1); else passes++;
            checks++; if (stall_cnt2 !== 3'(cnt2)) $display("FAIL rnd_cnt2_%0d got %0d exp %0d", k, stall_cnt2, cnt2); else passes++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_x0_unused();
        test_mdu();
        test_branch_vs_hazard();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
